// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-port arbiter in front of a single data memory. Requester 0
//               is the instruction-refill port, requester 1 the data-cache
//               port. Each accepted request runs an optional writeback phase
//               and/or a fetch phase, each LATENCY cycles long, and then
//               reports completion with a one-cycle done pulse.
// Ports       : clk, rst_n            clock, async active-low reset
//               req[1:0], op[3:0]     per-requester request / 2-bit opcode
//               addr, wb_addr, wb_data per-requester 32-bit words, packed
//               gnt, done             one-hot accept / completion pulses
//               rdata                 fetch result, held between fetches
//               mem_fetch, mem_A, mem_RD          memory read side
//               mem_writeback, mem_WB_addr, mem_WB_DATA  memory write side
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [1:0]                req,
  input  logic [3:0]                op,
  input  logic [2*DATA_WIDTH-1:0]   addr,
  input  logic [2*DATA_WIDTH-1:0]   wb_addr,
  input  logic [2*DATA_WIDTH-1:0]   wb_data,
  output logic [1:0]                gnt,
  output logic [1:0]                done,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic                      mem_fetch,
  output logic                      mem_writeback,
  output logic [DATA_WIDTH-1:0]     mem_A,
  output logic [DATA_WIDTH-1:0]     mem_WB_addr,
  output logic [DATA_WIDTH-1:0]     mem_WB_DATA,
  input  logic [DATA_WIDTH-1:0]     mem_RD
);

  localparam int       DW        = DATA_WIDTH;
  localparam logic [3:0] c_last  = 4'(LATENCY - 1);
  localparam logic [1:0] c_op_fetch = 2'b01;
  localparam logic [1:0] c_op_wb    = 2'b10;
  localparam logic [1:0] c_op_wbf   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WB    = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_rr;
  logic            r_idx;
  logic [1:0]      r_op;
  logic [DW-3:0]   r_addr;
  logic [DW-3:0]   r_wb_addr;
  logic [DW-1:0]   r_wb_data;
  logic [3:0]      r_cnt;

  logic            w_sel;
  logic            w_accept;
  logic [1:0]      w_win;
  logic [1:0]      w_served;
  logic [1:0]      w_op;
  logic [DW-3:0]   w_addr;
  logic [DW-3:0]   w_wb_addr;
  logic [DW-1:0]   w_wb_data;
  logic            w_unused;

  // Lone requester wins outright; on contention the round-robin pointer picks.
  assign w_sel     = (req == 2'b11) ? r_rr : req[1];
  assign w_accept  = (r_state == IDLE) && (req != 2'b00);
  assign w_win     = w_sel ? 2'b10 : 2'b01;
  assign w_served  = r_idx ? 2'b10 : 2'b01;

  assign w_op      = w_sel ? op[3:2] : op[1:0];
  assign w_addr    = w_sel ? addr[2*DW-1:DW+2]    : addr[DW-1:2];
  assign w_wb_addr = w_sel ? wb_addr[2*DW-1:DW+2] : wb_addr[DW-1:2];
  assign w_wb_data = w_sel ? wb_data[2*DW-1:DW]   : wb_data[DW-1:0];

  // Byte-offset bits are dropped: memory is always addressed word-aligned.
  assign w_unused  = ^{addr[DW+1:DW], addr[1:0], wb_addr[DW+1:DW], wb_addr[1:0]};

  // Accept pulse is combinational; gated by rst_n so it is silent in reset.
  assign gnt = (rst_n && w_accept) ? w_win : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_rr          <= 1'b0;
      r_idx         <= 1'b0;
      r_op          <= 2'b00;
      r_addr        <= '0;
      r_wb_addr     <= '0;
      r_wb_data     <= '0;
      r_cnt         <= 4'd0;
      done          <= 2'b00;
      rdata         <= '0;
      mem_fetch     <= 1'b0;
      mem_writeback <= 1'b0;
      mem_A         <= '0;
      mem_WB_addr   <= '0;
      mem_WB_DATA   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx     <= w_sel;
            r_op      <= w_op;
            r_addr    <= w_addr;
            r_wb_addr <= w_wb_addr;
            r_wb_data <= w_wb_data;
            r_cnt     <= 4'd0;
            case (w_op)
              c_op_fetch: begin
                r_state   <= FETCH;
                mem_fetch <= 1'b1;
                mem_A     <= {w_addr, 2'b00};
              end
              c_op_wb, c_op_wbf: begin
                r_state       <= WB;
                mem_WB_addr   <= {w_wb_addr, 2'b00};
                mem_WB_DATA   <= w_wb_data;
                // Single-cycle phase: the first WB cycle is also the last.
                mem_writeback <= (c_last == 4'd0);
              end
              default: begin
                r_state <= DONE;
                done    <= w_win;
                rdata   <= '0;
              end
            endcase
          end
        end

        WB: begin
          if (r_cnt == c_last) begin
            r_cnt         <= 4'd0;
            mem_writeback <= 1'b0;
            mem_WB_addr   <= '0;
            mem_WB_DATA   <= '0;
            if (r_op == c_op_wbf) begin
              r_state   <= FETCH;
              mem_fetch <= 1'b1;
              mem_A     <= {r_addr, 2'b00};
            end else begin
              r_state <= DONE;
              done    <= w_served;
            end
          end else begin
            r_cnt         <= r_cnt + 4'd1;
            // Registered strobe lands exactly on the final phase cycle.
            mem_writeback <= ((r_cnt + 4'd1) == c_last);
          end
        end

        FETCH: begin
          if (r_cnt == c_last) begin
            r_cnt     <= 4'd0;
            rdata     <= mem_RD;
            mem_fetch <= 1'b0;
            mem_A     <= '0;
            r_state   <= DONE;
            done      <= w_served;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        DONE: begin
          done    <= 2'b00;
          r_rr    <= ~r_idx;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter (DATA_WIDTH=32,
//               LATENCY=2). A vector table drives single transactions;
//               expected completions are queued at drive time and popped
//               when done appears. Hand-written sequences cover contention
//               from reset and reset during a writeback phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int DW  = 32;
  localparam int LAT = 2;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req;
  logic [3:0]      op;
  logic [2*DW-1:0] addr;
  logic [2*DW-1:0] wb_addr;
  logic [2*DW-1:0] wb_data;
  logic [1:0]      gnt;
  logic [1:0]      done;
  logic [DW-1:0]   rdata;
  logic            mem_fetch;
  logic            mem_writeback;
  logic [DW-1:0]   mem_A;
  logic [DW-1:0]   mem_WB_addr;
  logic [DW-1:0]   mem_WB_DATA;
  logic [DW-1:0]   mem_RD;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.DATA_WIDTH(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr),
    .wb_addr(wb_addr), .wb_data(wb_data), .gnt(gnt), .done(done),
    .rdata(rdata), .mem_fetch(mem_fetch), .mem_writeback(mem_writeback),
    .mem_A(mem_A), .mem_WB_addr(mem_WB_addr), .mem_WB_DATA(mem_WB_DATA),
    .mem_RD(mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a distinct, address-dependent word everywhere.
  function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
  endfunction
  assign mem_RD = mem_word(mem_A);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [3:0]  op;
    logic [63:0] addr;
    logic [63:0] wb_addr;
    logic [63:0] wb_data;
    logic [1:0]  exp_gnt;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [1:0]  done;
    logic [31:0] rdata;
    int          lat;
    int          wb_cnt;
    logic [31:0] wb_addr;
    logic [31:0] wb_data;
    int          fetch_cycles;
    logic [31:0] fetch_addr;
  } exp_t;

  exp_t sb[$];
  logic m_rr;
  logic [31:0] m_rdata;

  // One complete transaction: drive, check accept, watch phases, check done.
  task automatic do_txn(input vec_t v, input string tag);
    exp_t e, got;
    logic w;
    logic [1:0] o;
    int k;
    bit seen;
    bit a_idle_bad, a_fetch_bad;
    int wb_k;
    @(posedge clk); #1;
    req = v.req; op = v.op; addr = v.addr; wb_addr = v.wb_addr; wb_data = v.wb_data;
    @(negedge clk);
    check({tag, "_gnt"}, gnt, v.exp_gnt);

    w = (v.req == 2'b11) ? m_rr : v.req[1];
    o = w ? v.op[3:2] : v.op[1:0];
    e.done       = w ? 2'b10 : 2'b01;
    e.lat        = v.exp_lat;
    e.wb_cnt     = o[1] ? 1 : 0;
    e.wb_addr    = {(w ? v.wb_addr[63:34] : v.wb_addr[31:2]), 2'b00};
    e.wb_data    = w ? v.wb_data[63:32] : v.wb_data[31:0];
    e.fetch_cycles = o[0] ? LAT : 0;
    e.fetch_addr = {(w ? v.addr[63:34] : v.addr[31:2]), 2'b00};
    if (o == 2'b00)    m_rdata = 32'h0;
    else if (o[0])     m_rdata = mem_word(e.fetch_addr);
    e.rdata = m_rdata;
    sb.push_back(e);

    got = '{default: 0};
    seen = 0; a_idle_bad = 0; a_fetch_bad = 0; wb_k = 0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!mem_fetch && mem_A != 0) a_idle_bad = 1;
      if (mem_fetch) begin
        got.fetch_cycles++;
        if (mem_A != e.fetch_addr) a_fetch_bad = 1;
      end
      if (mem_writeback) begin
        got.wb_cnt++;
        wb_k = k;
        got.wb_addr = mem_WB_addr;
        got.wb_data = mem_WB_DATA;
      end
      if (done != 2'b00) begin
        seen = 1;
        got.done = done;
        got.rdata = rdata;
        got.lat = k;
        break;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    e = sb.pop_front();
    check({tag, "_done"}, got.done, e.done);
    check({tag, "_latency"}, got.lat, e.lat);
    check({tag, "_rdata"}, got.rdata, e.rdata);
    check({tag, "_wb_pulses"}, got.wb_cnt, e.wb_cnt);
    if (e.wb_cnt != 0) begin
      check({tag, "_wb_cycle"}, wb_k, LAT);
      check({tag, "_wb_addr"}, got.wb_addr, e.wb_addr);
      check({tag, "_wb_data"}, got.wb_data, e.wb_data);
    end
    check({tag, "_fetch_cycles"}, got.fetch_cycles, e.fetch_cycles);
    check({tag, "_fetch_addr_bad"}, a_fetch_bad, 0);
    check({tag, "_memA_idle_bad"}, a_idle_bad, 0);
    @(posedge clk); #1;
    req = 2'b00;
    m_rr = ~w;
  endtask

  vec_t vecs[8];
  logic [1:0]  q_gnt[$];
  exp_t        q_done[$];

  initial begin
    int n_done;
    exp_t ce;
    bit bad;

    // ---- reset with both requesters already asserting ----
    rst_n = 1'b0;
    req = 2'b11; op = 4'b0101;
    addr = {32'h0000_2001, 32'h0000_1003};
    wb_addr = '0; wb_data = '0;
    m_rr = 1'b0; m_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", gnt, 2'b00);
    check("rst_ctrl", {done, mem_fetch, mem_writeback}, 4'h0);
    check("rst_rdata", rdata, 0);
    check("rst_memA", mem_A, 0);
    check("rst_wb_bus", {mem_WB_addr, mem_WB_DATA}, 0);

    // ---- contention from reset: 0, 1, 0 ----
    q_gnt = '{2'b01, 2'b10, 2'b01};
    ce = '{default: 0};
    ce.done = 2'b01; ce.rdata = mem_word(32'h0000_1000); q_done.push_back(ce);
    ce.done = 2'b10; ce.rdata = mem_word(32'h0000_2000); q_done.push_back(ce);
    ce.done = 2'b01; ce.rdata = mem_word(32'h0000_1000); q_done.push_back(ce);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 40 && n_done < 3; k++) begin
      @(negedge clk);
      if (gnt != 2'b00) begin
        if (q_gnt.size() == 0) check("cont_extra_gnt", gnt, 2'b00);
        else check("cont_gnt", gnt, q_gnt.pop_front());
      end
      if (done != 2'b00) begin
        ce = q_done.pop_front();
        check("cont_done", done, ce.done);
        check("cont_rdata", rdata, ce.rdata);
        n_done++;
      end
    end
    check("cont_n_done", n_done, 3);
    @(posedge clk); #1;
    req = 2'b00;
    m_rr = 1'b1;
    m_rdata = mem_word(32'h0000_1000);

    // ---- table-driven single transactions ----
    vecs[0] = '{2'b01, 4'b0001, {32'h0, 32'h0001_0006}, 64'h0, 64'h0, 2'b01, 3};
    vecs[1] = '{2'b10, 4'b1100, {32'h0001_0020, 32'h0}, {32'h0001_0010, 32'h0},
                {32'hDEAD_BEEF, 32'h0}, 2'b10, 5};
    vecs[2] = '{2'b01, 4'b0010, 64'h0, {32'h0, 32'h0002_0003},
                {32'h0, 32'h1234_5678}, 2'b01, 3};
    vecs[3] = '{2'b10, 4'b0000, {32'h0009_0000, 32'h0}, 64'h0, 64'h0, 2'b10, 1};
    vecs[4] = '{2'b10, 4'b1000, 64'h0, {32'h0003_000F, 32'h0},
                {32'hCAFE_F00D, 32'h0}, 2'b10, 3};
    vecs[5] = '{2'b11, 4'b1001, {32'h0, 32'h0004_0001}, {32'h0005_0002, 32'h0},
                {32'h0BAD_C0DE, 32'h0}, 2'b01, 3};
    vecs[6] = '{2'b11, 4'b1001, {32'h0, 32'h0004_0001}, {32'h0005_0002, 32'h0},
                {32'h0BAD_C0DE, 32'h0}, 2'b10, 3};
    vecs[7] = '{2'b11, 4'b0111, {32'h0, 32'h0006_000B}, {32'h0, 32'h0007_0007},
                {32'h0, 32'h55AA_55AA}, 2'b01, 5};
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // ---- reset during the first writeback cycle ----
    @(posedge clk); #1;
    req = 2'b10; op = 4'b1000;
    wb_addr = {32'h0008_0000, 32'h0}; wb_data = {32'h1111_2222, 32'h0};
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_ctrl", {gnt, done, mem_fetch, mem_writeback}, 6'h0);
    check("midrst_rdata", rdata, 0);
    check("midrst_memA", mem_A, 0);
    check("midrst_wb_bus", {mem_WB_addr, mem_WB_DATA}, 0);
    req = 2'b00;
    m_rr = 1'b0; m_rdata = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_writeback || done != 2'b00) bad = 1;
    end
    check("midrst_aborted", bad, 0);
    do_txn(vecs[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
